// File: rtl/vec_sweep_capture.sv
// vec_sweep_capture
//   Sweeps a 4-bit input vector x through 0000..1111 into an external
//   2-output combinational function block, holding each vector for HOLD
//   cycles, and captures the block's response F into a 32-bit truth table.
//
//   Optional feature macro: VEC_SWEEP_SELF_CHECK_EN
//     defined   -> each captured F is compared against the golden function
//                  G1 = x1|(~x4&(x2|x3)), G2 = (x1|x2|x4)&(x1|~x3|~x4);
//                  mismatches are counted in err_cnt (saturating at 16).
//     undefined -> err_cnt is tied to 0 and no checker logic exists.
//
//   Parameters
//     HOLD     cycles each vector is driven before F is sampled (1..15)
//
//   Ports
//     clk      in   single clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     start    in   request a full 16-vector sweep (accepted only in IDLE)
//     x        out  [1:4] vector to the function block, x[1] is MSB
//     F        in   [1:2] function-block response to x
//     busy     out  high while a sweep is in progress
//     done     out  one-cycle pulse at sweep completion
//     tbl      out  [31:0] truth table, tbl[2k+1]=F[1], tbl[2k]=F[2] for x=k
//     err_cnt  out  [4:0] golden-function mismatch count
module vec_sweep_capture #(
  parameter int unsigned HOLD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:4]  x,
  input  logic [1:2]  F,
  output logic        busy,
  output logic        done,
  output logic [31:0] tbl,
  output logic [4:0]  err_cnt
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  x_q, x_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tbl_q, tbl_d;
  logic        sample;
  logic        accept;
  logic [4:0]  slot;

  // Sample edge: last cycle of the hold window for the current vector.
  assign sample = (state_q == DRIVE) && (cnt_q == HOLD_LAST);
  assign accept = (state_q == IDLE) && start;
  // Each vector owns a 2-bit slot of the table starting at bit 2k.
  assign slot   = {x_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    case (state_q)
      IDLE: begin
        x_d   = '0;
        cnt_d = '0;
        if (start) begin
          state_d = DRIVE;
          tbl_d   = '0;
        end
      end
      DRIVE: begin
        if (sample) begin
          cnt_d             = '0;
          tbl_d[slot +: 2]  = {F[1], F[2]};
          if (x_q == 4'hF) begin
            // Hold the last vector while done is signalled.
            state_d = DONE;
          end else begin
            x_d = x_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign x    = x_q;
  assign busy = (state_q == DRIVE);
  assign done = (state_q == DONE);
  assign tbl  = tbl_q;

`ifdef VEC_SWEEP_SELF_CHECK_EN
  logic [4:0] err_q, err_d;

  function automatic logic [1:0] golden(input logic [3:0] v);
    logic x1, x2, x3, x4;
    x1 = v[3];
    x2 = v[2];
    x3 = v[1];
    x4 = v[0];
    golden = {x1 | (~x4 & (x2 | x3)),
              (x1 | x2 | x4) & (x1 | ~x3 | ~x4)};
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    sat_inc = (v >= 5'd16) ? 5'd16 : v + 5'd1;
  endfunction

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = '0;
    end else if (sample && ({F[1], F[2]} != golden(x_q))) begin
      err_d = sat_inc(err_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/vec_sweep_capture.md
VEC_SWEEP_CAPTURE -- requirements
Module: vec_sweep_capture

Interface
REQ-001 Parameter HOLD, default 2: cycles each input vector is driven before F is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a full 16-vector sweep; sampled on clk edge.
REQ-005 x  output  [1:4]  vector driven to the downstream 2-output function block; x[1] is MSB.
REQ-006 F  input  [1:2]  function-block response to x.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse at sweep completion.
REQ-009 tbl  output  [31:0]  captured truth table; tbl[2k+1]=F[1], tbl[2k]=F[2] for x=k.
REQ-010 err_cnt  output  [4:0]  count of vectors whose captured F mismatches the golden function (see Configuration).

Function
REQ-011 The block SHALL use a registered FSM with states IDLE, DRIVE, DONE; busy = (state==DRIVE), done = (state==DONE).
REQ-012 In IDLE, start=1 at an edge SHALL move to DRIVE, set x=0000, clear hold counter, clear tbl and err_cnt.
REQ-013 start SHALL be ignored in DRIVE and DONE; no re-trigger, no restart.
REQ-014 In DRIVE, the hold counter SHALL increment each edge; at the edge where counter==HOLD-1 the block SHALL write F into the tbl slot for current x and reset the counter.
REQ-015 At that sample edge, if x!=1111 the block SHALL increment x; if x==1111 it SHALL move to DONE and keep x=1111.
REQ-016 Each vector SHALL therefore be driven for exactly HOLD cycles; done SHALL rise 16*HOLD edges after the start-acceptance edge.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; a start held high SHALL begin the next sweep from that IDLE cycle (one idle cycle between sweeps).
REQ-018 tbl and err_cnt SHALL hold their final values in IDLE until the next accepted start.
REQ-019 Slots of tbl not yet sampled in the current sweep SHALL read 0.
REQ-020 x SHALL return to 0000 on entry to IDLE.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, x=0000, busy=0, done=0, hold counter=0, tbl=0, err_cnt=0.
REQ-022 Reset during DRIVE SHALL abort the sweep with no done pulse; the first edge after release with start=1 SHALL begin a fresh sweep.

Configuration
REQ-023 Macro VEC_SWEEP_SELF_CHECK_EN, when defined, SHALL compute golden G1 = x1|(~x4&(x2|x3)), G2 = (x1|x2|x4)&(x1|~x3|~x4) and increment err_cnt (saturating at 16) at each sample edge where F!={G1,G2}.
REQ-024 Without VEC_SWEEP_SELF_CHECK_EN, err_cnt SHALL be tied to 0 and no checker logic SHALL be synthesised; all other behaviour is identical.

Verification
REQ-025 Correct function block connected, HOLD=2, single start pulse -> busy 32 cycles, done pulse 32 edges after acceptance, tbl=32'hFFFF3724, err_cnt=0.
REQ-026 F tied to 2'b00, macro defined -> tbl=32'h00000000, err_cnt=13 at done.
REQ-027 Reset asserted 10 cycles into a sweep -> all outputs 0 immediately, no done; subsequent start completes a full sweep with tbl=32'hFFFF3724.
REQ-028 start pulsed again during DRIVE -> ignored, done timing unchanged; start held high continuously -> done pulses every 34 cycles (HOLD=2).
REQ-029 HOLD=1 -> x steps every cycle 0000..1111, done 16 edges after acceptance, tbl=32'hFFFF3724.
REQ-030 Macro undefined, F tied to 2'b00 -> err_cnt=0 throughout, tbl=32'h00000000.
